mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multicycle CPU between the CPU datapath, driven by the Controller's MemRead/MemWrite/IorD sequencing, and the program loader/debug port. It serialises requests and alternates grants round-robin under contention. It runs each access through a fixed-latency memory handshake and returns read data plus a one-cycle acknowledge to the winning requester. While its access is pending, the arbiter drives a stall to the Controller so the FSM holds its current state.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 32, memory data width
- MEM_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid; legal range 1..7

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  last CPU read result, held
- cpu_stall  out  1  cpu_req & ~cpu_ack, to the Controller
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as the CPU port
- ld_ack  out  1  loader completion pulse
- ld_rdata  out  DATA_W  last loader read result, held
- mem_en  out  1  memory strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is present, pick a winner and latch its we, addr, wdata and grant id. Go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection in IDLE:
  - Single requester: that requester wins.
  - Both requesting: the requester not granted last time wins.
  - The last-grant pointer resets to "loader", so the CPU wins the first contention.
- ISSUE: assert mem_en=1 and mem_we=latched we, with mem_addr/mem_wdata from the latched values. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture mem_rdata into the winner's rdata register; reads only, writes leave rdata unchanged. Go to DONE.
- DONE: pulse the winner's ack for one cycle and update the last-grant pointer. Go to IDLE.
- Requests are not sampled in ISSUE, WAIT or DONE. A requester whose req is still high in DONE is not re-served, because it must drop req after seeing ack.
- mem_addr and mem_wdata hold their latched values outside ISSUE. mem_en and mem_we are 0 outside ISSUE.
- Reset values: state IDLE, all acks 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, ld_rdata 0, busy 0, counter 0. cpu_stall follows cpu_req, since it is combinational.
- Reset asserted mid-transaction: the access is aborted, no ack is issued, and a still-held req is served again from scratch after reset releases.

## Timing
- Taking the cycle in which a request is sampled in IDLE as cycle 0:
  - mem_en is high in cycle 1.
  - WAIT occupies cycles 2..1+MEM_LAT.
  - ack and valid rdata appear in cycle 2+MEM_LAT.
- Request-to-ack latency is 2+MEM_LAT cycles. Throughput is one access per 3+MEM_LAT cycles, including the IDLE return.
- All outputs are registered except cpu_stall.
- Under contention with both requests held continuously, grants strictly alternate: C, L, C, L, …

## Structure
- Shared package holds:
  - the state encodings, 2 bits: IDLE=0, ISSUE=1, WAIT=2, DONE=3
  - the grant ids: GNT_CPU=0, GNT_LD=1
- Sub-module rr_arbiter2: a combinational two-input round-robin picker. Inputs are req[1:0] and the last-grant pointer; the output is the grant id. The pointer register stays in the parent.

## Test plan
- CPU read alone, MEM_LAT=1, cpu_addr=0x0010, memory model returns 0xDEADBEEF → mem_en high only in cycle 1 with mem_addr=0x0010; cpu_ack in cycle 3; cpu_rdata=0xDEADBEEF and held; ld_ack stays 0.
- Both requests high right after reset, each held for 4 transactions → grant order C, L, C, L; each ack spaced 4 cycles apart; busy drops only in the IDLE cycles.
- Loader writes 0x12345678 to 0x0020, then CPU reads 0x0020 → mem_we=1 only in the loader's ISSUE cycle; cpu_rdata=0x12345678; ld_rdata unchanged by the write.
- MEM_LAT=3, CPU read → ack in cycle 5; mem_en high exactly one cycle; rdata captured from the cycle-4 mem_rdata value.
- reset driven low during WAIT of a CPU read, cpu_req held → all outputs 0 immediately; no ack; after release the read is re-served with a fresh mem_en; cpu_ack arrives 2+MEM_LAT cycles later.
- cpu_stall check → high from the first cycle of cpu_req through the cycle before cpu_ack; low in the cpu_ack cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encodings,
// grant ids and the latency counter width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_LD  = 1'b1
  } grantId_t;

  // Wide enough for the largest legal memory latency (7).
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-input round-robin picker; req[0] is the CPU, req[1] the loader.
// The last-grant pointer lives in the parent.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  grantId_t   lastGrant,
  output grantId_t   grant_c
);

  // Under contention the side that did not win last time goes next.
  always_comb begin
    grant_c = GNT_CPU;
    if (req == 2'b10) begin
      grant_c = GNT_LD;
    end else if (req == 2'b11) begin
      grant_c = (lastGrant == GNT_CPU) ? GNT_LD : GNT_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the multicycle CPU's unified memory between the datapath and the
// loader/debug port, one fixed-latency access at a time, with a stall to the Controller.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arbState_t         state, stateNext;
  grantId_t          lastGrant, lastGrantNext;
  grantId_t          winner, winnerNext;
  grantId_t          pick;
  logic              weLat, weLatNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              memEnNext, memWeNext, busyNext;
  logic              cpuAckNext, ldAckNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext, cpuRdataNext, ldRdataNext;

  rr_arbiter2 u_rr (
    .req       ({ld_req, cpu_req}),
    .lastGrant (lastGrant),
    .grant_c   (pick)
  );

  // The Controller holds its state until its own ack arrives.
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lastGrant <= GNT_LD;
      winner    <= GNT_CPU;
      weLat     <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      winner    <= winnerNext;
      weLat     <= weLatNext;
      cnt       <= cntNext;
      mem_en    <= memEnNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      cpu_ack   <= cpuAckNext;
      ld_ack    <= ldAckNext;
      cpu_rdata <= cpuRdataNext;
      ld_rdata  <= ldRdataNext;
      busy      <= busyNext;
    end
  end

  // Outputs are computed one cycle ahead so the memory strobe coincides with ISSUE
  // and the ack with DONE.
  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    winnerNext    = winner;
    weLatNext     = weLat;
    cntNext       = cnt;
    memEnNext     = 1'b0;
    memWeNext     = 1'b0;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    cpuAckNext    = 1'b0;
    ldAckNext     = 1'b0;
    cpuRdataNext  = cpu_rdata;
    ldRdataNext   = ld_rdata;

    case (state)
      IDLE: begin
        if (cpu_req || ld_req) begin
          winnerNext   = pick;
          weLatNext    = (pick == GNT_LD) ? ld_we    : cpu_we;
          memAddrNext  = (pick == GNT_LD) ? ld_addr  : cpu_addr;
          memWdataNext = (pick == GNT_LD) ? ld_wdata : cpu_wdata;
          memEnNext    = 1'b1;
          memWeNext    = weLatNext;
          stateNext    = ISSUE;
        end
      end
      ISSUE: begin
        cntNext   = CNT_W'(MEM_LAT);
        stateNext = WAIT;
      end
      WAIT: begin
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (!weLat) begin
            if (winner == GNT_LD) ldRdataNext  = mem_rdata;
            else                  cpuRdataNext = mem_rdata;
          end
          cpuAckNext = (winner == GNT_CPU);
          ldAckNext  = (winner == GNT_LD);
          stateNext  = DONE;
        end
      end
      DONE: begin
        lastGrantNext = winner;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 instance (index 0) for most cases,
// MEM_LAT=3 instance (index 1) for the latency case, each with its own memory model.
module tb_mem_port_arbiter;

  typedef struct {
    logic        isLd;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] expCpu;
    logic [31:0] expLd;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        memClr;
  logic        cpuReq[2], cpuWe[2], ldReq[2], ldWe[2];
  logic [15:0] cpuAddr[2], ldAddr[2], memAddr[2];
  logic [31:0] cpuWdata[2], ldWdata[2], memWdata[2], memRdata[2];
  logic [31:0] cpuRdata[2], ldRdata[2];
  logic        cpuAck[2], cpuStall[2], ldAck[2], memEn[2], memWe[2], busy[2];
  int          nChecks = 0;
  int          nFail = 0;
  vec_t        vecs[7];

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(cpuReq[0]), .cpu_we(cpuWe[0]), .cpu_addr(cpuAddr[0]), .cpu_wdata(cpuWdata[0]),
    .cpu_ack(cpuAck[0]), .cpu_rdata(cpuRdata[0]), .cpu_stall(cpuStall[0]),
    .ld_req(ldReq[0]), .ld_we(ldWe[0]), .ld_addr(ldAddr[0]), .ld_wdata(ldWdata[0]),
    .ld_ack(ldAck[0]), .ld_rdata(ldRdata[0]),
    .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
    .mem_rdata(memRdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .cpu_req(cpuReq[1]), .cpu_we(cpuWe[1]), .cpu_addr(cpuAddr[1]), .cpu_wdata(cpuWdata[1]),
    .cpu_ack(cpuAck[1]), .cpu_rdata(cpuRdata[1]), .cpu_stall(cpuStall[1]),
    .ld_req(ldReq[1]), .ld_we(ldWe[1]), .ld_addr(ldAddr[1]), .ld_wdata(ldWdata[1]),
    .ld_ack(ldAck[1]), .ld_rdata(ldRdata[1]),
    .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
    .mem_rdata(memRdata[1]), .busy(busy[1])
  );

  // Memory model: read data is valid only in the single cycle MEM_LAT after mem_en.
  logic [1:0][255:0][31:0] memArr;
  logic [1:0][255:0]       wr;
  logic [1:0][2:0]         rem;
  logic [1:0][7:0]         pend;

  function automatic logic [31:0] defWord(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h30:   return 32'hCAFEF00D;
      default: return {24'h5A5A5A, a};
    endcase
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (memClr) begin
        wr[i]  <= '0;
        rem[i] <= '0;
      end else if (memEn[i]) begin
        if (memWe[i]) begin
          memArr[i][memAddr[i][7:0]] <= memWdata[i];
          wr[i][memAddr[i][7:0]]     <= 1'b1;
        end
        rem[i]  <= (i == 0) ? 3'd1 : 3'd3;
        pend[i] <= memAddr[i][7:0];
      end else if (rem[i] != 3'd0) begin
        rem[i] <= rem[i] - 3'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      memRdata[i] = 32'hBAD00000 | 32'(rem[i]);
      if (rem[i] == 3'd1)
        memRdata[i] = wr[i][pend[i]] ? memArr[i][pend[i]] : defWord(pend[i]);
    end
  end

  task automatic chkB(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkW(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One access on the MEM_LAT=1 instance, starting from a negedge in IDLE.
  task automatic runVec(input vec_t v, input int vi);
    if (v.isLd) begin
      ldReq[0] = 1'b1; ldWe[0] = v.we; ldAddr[0] = v.addr; ldWdata[0] = v.wdata;
    end else begin
      cpuReq[0] = 1'b1; cpuWe[0] = v.we; cpuAddr[0] = v.addr; cpuWdata[0] = v.wdata;
    end
    #1 chkB($sformatf("v%0d k0 cpu_stall", vi), cpuStall[0], !v.isLd);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chkB($sformatf("v%0d k%0d mem_en", vi, k), memEn[0], k == 1);
      chkB($sformatf("v%0d k%0d mem_we", vi, k), memWe[0], (k == 1) && v.we);
      if (k == 1) begin
        chkW($sformatf("v%0d mem_addr", vi), 32'(memAddr[0]), 32'(v.addr));
        if (v.we) chkW($sformatf("v%0d mem_wdata", vi), memWdata[0], v.wdata);
      end
      chkB($sformatf("v%0d k%0d cpu_ack", vi, k), cpuAck[0], (k == 3) && !v.isLd);
      chkB($sformatf("v%0d k%0d ld_ack", vi, k), ldAck[0], (k == 3) && v.isLd);
      chkB($sformatf("v%0d k%0d busy", vi, k), busy[0], k < 4);
      chkB($sformatf("v%0d k%0d cpu_stall", vi, k), cpuStall[0], !v.isLd && (k < 3));
      if (k >= 3) begin
        chkW($sformatf("v%0d k%0d cpu_rdata", vi, k), cpuRdata[0], v.expCpu);
        chkW($sformatf("v%0d k%0d ld_rdata", vi, k), ldRdata[0], v.expLd);
      end
      if (k == 3) begin
        cpuReq[0] = 1'b0;
        ldReq[0]  = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t rv;
    int   ph, t;
    reset  = 1'b0;
    memClr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cpuReq[i] = 1'b0; cpuWe[i] = 1'b0; cpuAddr[i] = '0; cpuWdata[i] = '0;
      ldReq[i]  = 1'b0; ldWe[i]  = 1'b0; ldAddr[i]  = '0; ldWdata[i]  = '0;
    end
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 16'h0020, 32'h0,        32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 16'h0030, 32'h0,        32'h12345678, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b1, 16'h0040, 32'hA5A5A5A5, 32'h12345678, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 16'h0040, 32'h0,        32'h12345678, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 1'b0, 16'h0055, 32'h0,        32'h5A5A5A55, 32'hA5A5A5A5};

    repeat (2) @(negedge clock);
    memClr = 1'b0;
    #1;
    chkB("rst cpu_ack", cpuAck[0], 1'b0);
    chkB("rst ld_ack", ldAck[0], 1'b0);
    chkB("rst mem_en", memEn[0], 1'b0);
    chkB("rst mem_we", memWe[0], 1'b0);
    chkW("rst mem_addr", 32'(memAddr[0]), 32'h0);
    chkW("rst mem_wdata", memWdata[0], 32'h0);
    chkW("rst cpu_rdata", cpuRdata[0], 32'h0);
    chkW("rst ld_rdata", ldRdata[0], 32'h0);
    chkB("rst busy", busy[0], 1'b0);
    chkB("rst cpu_stall", cpuStall[0], 1'b0);

    // Contention from reset: C, L, C, L, each access four cycles long.
    @(negedge clock);
    reset = 1'b1;
    cpuReq[0] = 1'b1; cpuAddr[0] = 16'h0010;
    ldReq[0]  = 1'b1; ldAddr[0]  = 16'h0030;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      ph = k % 4;
      t  = k / 4;
      chkB($sformatf("rr k%0d mem_en", k), memEn[0], ph == 1);
      if (ph == 1)
        chkW($sformatf("rr k%0d mem_addr", k), 32'(memAddr[0]), (t % 2 == 1) ? 32'h30 : 32'h10);
      chkB($sformatf("rr k%0d cpu_ack", k), cpuAck[0], (ph == 3) && (t % 2 == 0));
      chkB($sformatf("rr k%0d ld_ack", k), ldAck[0], (ph == 3) && (t % 2 == 1));
      chkB($sformatf("rr k%0d busy", k), busy[0], ph != 0);
      chkB($sformatf("rr k%0d cpu_stall", k), cpuStall[0], (k < 16) && !((ph == 3) && (t % 2 == 0)));
      if (ph == 3 && t % 2 == 0) chkW($sformatf("rr k%0d cpu_rdata", k), cpuRdata[0], 32'hDEADBEEF);
      if (ph == 3 && t % 2 == 1) chkW($sformatf("rr k%0d ld_rdata", k), ldRdata[0], 32'hCAFEF00D);
      if (k == 15) begin
        cpuReq[0] = 1'b0;
        ldReq[0]  = 1'b0;
      end
    end

    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) runVec(vecs[i], i);

    // Reset during WAIT of a CPU read; the held request is served again afterwards.
    cpuReq[0] = 1'b1; cpuWe[0] = 1'b0; cpuAddr[0] = 16'h0010;
    @(negedge clock);
    chkB("rw issue mem_en", memEn[0], 1'b1);
    @(negedge clock);
    chkB("rw wait busy", busy[0], 1'b1);
    reset = 1'b0;
    #1;
    chkB("rw rst mem_en", memEn[0], 1'b0);
    chkB("rw rst busy", busy[0], 1'b0);
    chkB("rw rst cpu_ack", cpuAck[0], 1'b0);
    chkW("rw rst mem_addr", 32'(memAddr[0]), 32'h0);
    chkW("rw rst cpu_rdata", cpuRdata[0], 32'h0);
    chkW("rw rst ld_rdata", ldRdata[0], 32'h0);
    chkB("rw rst cpu_stall", cpuStall[0], 1'b1);
    @(negedge clock);
    chkB("rw hold cpu_ack", cpuAck[0], 1'b0);
    reset = 1'b1;
    rv = '{1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 32'h0};
    runVec(rv, 90);

    // MEM_LAT=3 read: ack in cycle 5, data taken from the cycle-4 memory value.
    cpuReq[1] = 1'b1; cpuWe[1] = 1'b0; cpuAddr[1] = 16'h0030;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chkB($sformatf("lat3 k%0d mem_en", k), memEn[1], k == 1);
      chkB($sformatf("lat3 k%0d cpu_ack", k), cpuAck[1], k == 5);
      chkB($sformatf("lat3 k%0d ld_ack", k), ldAck[1], 1'b0);
      chkB($sformatf("lat3 k%0d busy", k), busy[1], k < 6);
      chkB($sformatf("lat3 k%0d cpu_stall", k), cpuStall[1], k < 5);
      chkW($sformatf("lat3 k%0d cpu_rdata", k), cpuRdata[1], (k >= 5) ? 32'hCAFEF00D : 32'h0);
      if (k == 5) cpuReq[1] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
